// File: rtl/rca_adder_sequencer.sv
// Issue-to-writeback sequencer for the reconfigurable-unit adder: one execute
// register stage feeding an external adder, then an in-order result buffer.
module rca_adder_sequencer #(
  parameter int XLEN  = 32,
  parameter int ID_W  = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_new,
  input  logic [ID_W-1:0]            issue_id,
  input  logic [XLEN-1:0]            issue_rs1,
  input  logic [XLEN-1:0]            issue_rs2,
  output logic                       issue_ready,
  output logic [XLEN-1:0]            adder_a,
  output logic [XLEN-1:0]            adder_b,
  input  logic [XLEN-1:0]            adder_sum,
  output logic                       wb_done,
  output logic [ID_W-1:0]            wb_id,
  output logic [XLEN-1:0]            wb_rd,
  input  logic                       wb_ack,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] rd;
  } res_t;

  res_t [DEPTH-1:0] mem;
  logic             exec_valid;
  logic [ID_W-1:0]  exec_id;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             accept, wr, pop;

  // Credits count the execute stage too, so a buffer write never finds it full.
  assign occupancy   = count + CW'(exec_valid);
  assign issue_ready = occupancy < CW'(DEPTH);
  assign accept      = issue_new & issue_ready;
  assign wr          = exec_valid;
  assign wb_done     = count != '0;
  assign pop         = wb_done & wb_ack;
  assign wb_id       = mem[head].id;
  assign wb_rd       = mem[head].rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_valid <= 1'b0;
      exec_id    <= '0;
      adder_a    <= '0;
      adder_b    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      mem        <= '0;
    end else begin
      exec_valid <= accept;
      if (accept) begin
        exec_id <= issue_id;
        adder_a <= issue_rs1;
        adder_b <= issue_rs2;
      end
      if (wr) begin
        mem[tail] <= '{id: exec_id, rd: adder_sum};
        tail      <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occupancy <= CW'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> count != '0);
  a_no_wr_full: assert property (@(posedge clk) disable iff (rst) wr |-> count != CW'(DEPTH));

endmodule
